// File: rtl/viterbi_codec.sv
// Rate-1/2 K=3 (7,5) convolutional encoder plus 4-state hard-decision register-exchange Viterbi decoder.
// Optional macro VITERBI_ERR_CNT_EN adds dec_err_cnt_o (accumulated best-path error weight).
module viterbi_codec #(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enc_enable_i,
   input  logic       enc_d_i,
   output logic       enc_valid_o,
   output logic [1:0] enc_d_o,
   input  logic       dec_enable_i,
   input  logic [1:0] dec_d_i,
   output logic       dec_valid_o,
   output logic       dec_d_o
`ifdef VITERBI_ERR_CNT_EN
   ,
   output logic [15:0] dec_err_cnt_o
`endif
);

   localparam int WW = $clog2(TB_DEPTH);
   localparam logic [WW-1:0]   WARM_MAX = WW'(TB_DEPTH - 1);
   localparam logic [PM_W-1:0] PM_MAX   = '1;
   localparam int PM_INIT_I = (((1 << PM_W) - 1) < 16) ? ((1 << PM_W) - 1) : 16;
   localparam logic [PM_W-1:0] PM_INIT  = PM_INIT_I[PM_W-1:0];

   // ---------------- encoder ----------------
   logic [1:0] enc_s_q, enc_s_d;
   logic [1:0] enc_sym_q, enc_sym_d;
   logic       enc_vld_q;

   always_comb begin
      enc_s_d   = enc_s_q;
      enc_sym_d = enc_sym_q;
      if (enc_enable_i) begin
         enc_sym_d = {enc_d_i ^ enc_s_q[1] ^ enc_s_q[0], enc_d_i ^ enc_s_q[0]};
         enc_s_d   = {enc_d_i, enc_s_q[1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enc_s_q   <= '0;
         enc_sym_q <= '0;
         enc_vld_q <= 1'b0;
      end else begin
         enc_s_q   <= enc_s_d;
         enc_sym_q <= enc_sym_d;
         enc_vld_q <= enc_enable_i;
      end
   end

   assign enc_d_o     = enc_sym_q;
   assign enc_valid_o = enc_vld_q;

   // ---------------- decoder ----------------
   logic [3:0][PM_W-1:0]     pm_q, pm_d, pm_raw;
   logic [3:0][TB_DEPTH-1:0] surv_q, surv_d;
   logic [WW-1:0]            warm_q;
   logic                     dec_d_q, dec_vld_q;
   logic [PM_W-1:0]          pm_min;
   logic [1:0]               best;

   function automatic logic [1:0] hdist(input logic [1:0] x);
      return {1'b0, x[1]} + {1'b0, x[0]};
   endfunction

   function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
      logic [PM_W:0] s;
      s = {1'b0, pm} + (PM_W+1)'(bm);
      return s[PM_W] ? PM_MAX : s[PM_W-1:0];
   endfunction

   // Next state n = {d,a}; predecessors {a,0} and {a,1}; ties favour {a,0}.
   always_comb begin
      logic [PM_W-1:0] c0, c1;
      logic            d, a;
      pm_raw = '0;
      surv_d = '0;
      pm_d   = '0;
      pm_min = '0;
      best   = 2'd0;
      c0     = '0;
      c1     = '0;
      d      = 1'b0;
      a      = 1'b0;
      for (int n = 0; n < 4; n++) begin
         d  = n[1];
         a  = n[0];
         c0 = sat_add(pm_q[{a, 1'b0}], hdist(dec_d_i ^ {d ^ a, d}));
         c1 = sat_add(pm_q[{a, 1'b1}], hdist(dec_d_i ^ {d ^ a ^ 1'b1, ~d}));
         if (c1 < c0) begin
            pm_raw[n] = c1;
            surv_d[n] = {surv_q[{a, 1'b1}][TB_DEPTH-2:0], d};
         end else begin
            pm_raw[n] = c0;
            surv_d[n] = {surv_q[{a, 1'b0}][TB_DEPTH-2:0], d};
         end
      end
      for (int i = 1; i < 4; i++)
         if (pm_raw[i] < pm_raw[best]) best = 2'(i);
      pm_min = pm_raw[best];
      for (int i = 0; i < 4; i++)
         pm_d[i] = pm_raw[i] - pm_min;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pm_q      <= {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
         surv_q    <= '0;
         warm_q    <= '0;
         dec_d_q   <= 1'b0;
         dec_vld_q <= 1'b0;
      end else begin
         dec_vld_q <= dec_enable_i && (warm_q == WARM_MAX);
         if (dec_enable_i) begin
            pm_q    <= pm_d;
            surv_q  <= surv_d;
            dec_d_q <= surv_d[best][TB_DEPTH-1];
            if (warm_q != WARM_MAX) warm_q <= warm_q + 1'b1;
         end
      end
   end

   assign dec_d_o     = dec_d_q;
   assign dec_valid_o = dec_vld_q;

`ifdef VITERBI_ERR_CNT_EN
   // The normalization amount equals the error weight added to the surviving best path.
   logic [15:0] err_cnt_q;
   logic [16:0] err_sum;
   assign err_sum = {1'b0, err_cnt_q} + 17'(pm_min);

   always_ff @(posedge clk) begin
      if (rst)
         err_cnt_q <= '0;
      else if (dec_enable_i)
         err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   assign dec_err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_codec.sv
// Directed bench for viterbi_codec: encoder vector, loopback, error correction, enable gaps, mid-stream reset.
module tb_viterbi_codec;
   localparam int TBD = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       enc_enable_i, enc_d_i, enc_valid_o;
   logic [1:0] enc_d_o;
   logic       dec_enable_i;
   logic [1:0] dec_d_i;
   logic       dec_valid_o, dec_d_o;
`ifdef VITERBI_ERR_CNT_EN
   logic [15:0] dec_err_cnt_o;
`endif

   logic loop_en, flip;
   assign dec_enable_i = loop_en & enc_valid_o;
   assign dec_d_i      = enc_d_o ^ {flip, 1'b0};

   always #5 clk = ~clk;

   viterbi_codec #(.TB_DEPTH(TBD), .PM_W(6)) dut (
      .clk(clk), .rst(rst),
      .enc_enable_i(enc_enable_i), .enc_d_i(enc_d_i),
      .enc_valid_o(enc_valid_o), .enc_d_o(enc_d_o),
      .dec_enable_i(dec_enable_i), .dec_d_i(dec_d_i),
      .dec_valid_o(dec_valid_o), .dec_d_o(dec_d_o)
`ifdef VITERBI_ERR_CNT_EN
      , .dec_err_cnt_o(dec_err_cnt_o)
`endif
   );

   int errs = 0, checks = 0;
   bit hist[$];
   int sym;
   bit err_mode, known, exp_d;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reset with enables asserted; those enables must be ignored.
   task automatic do_reset();
      rst = 1'b1; enc_enable_i = 1'b1; enc_d_i = 1'b1; flip = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_enc_d", enc_d_o, 0);
      chk("rst_enc_valid", enc_valid_o, 0);
      chk("rst_dec_d", dec_d_o, 0);
      chk("rst_dec_valid", dec_valid_o, 0);
      hist.delete();
      sym = 0; known = 0; exp_d = 0;
   endtask

   task automatic cyc(input bit en, input bit d);
      bit acc;
      int j;
      enc_enable_i = en; enc_d_i = d;
      flip = err_mode && (sym % 8 == 7);
      acc  = dec_enable_i;
      j    = sym;
      if (en) hist.push_back(d);
      @(posedge clk); #1;
      chk("enc_valid", enc_valid_o, en);
      if (acc) begin
         sym++;
         if (j >= TBD - 1) begin
            exp_d = hist[j - (TBD - 1)];
            known = 1;
            chk("dec_valid", dec_valid_o, 1);
            chk("dec_d", dec_d_o, exp_d);
         end else begin
            known = 0;
            chk("dec_valid_warmup", dec_valid_o, 0);
         end
      end else begin
         chk("dec_valid_idle", dec_valid_o, 0);
         if (known) chk("dec_d_hold", dec_d_o, exp_d);
      end
   endtask

   task automatic run_stream(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      bit         vb[6];
      logic [1:0] ve[6];
      vb = '{1, 0, 1, 1, 0, 0};
      ve = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
      rst = 1'b1; enc_enable_i = 0; enc_d_i = 0; loop_en = 0; flip = 0; err_mode = 0;
      void'($urandom(32'h5eed));

      // Encoder directed vector
      do_reset();
      for (int i = 0; i < 6; i++) begin
         enc_enable_i = 1'b1; enc_d_i = vb[i];
         @(posedge clk); #1;
         chk("enc_sym", enc_d_o, ve[i]);
         chk("enc_sym_valid", enc_valid_o, 1);
      end
      enc_enable_i = 1'b0;
      @(posedge clk); #1;
      chk("enc_hold_sym", enc_d_o, 2'b11);
      chk("enc_hold_valid", enc_valid_o, 0);

      // Clean loopback
      loop_en = 1'b1;
      do_reset();
      run_stream(256);
      cyc(1'b0, 1'b0);
`ifdef VITERBI_ERR_CNT_EN
      chk("err_cnt_clean", dec_err_cnt_o, 0);
`endif

      // Error correction: g0 flipped on every 8th symbol
      err_mode = 1'b1;
      do_reset();
      run_stream(256);
      cyc(1'b0, 1'b0);
`ifdef VITERBI_ERR_CNT_EN
      chk("err_cnt_32pm1", (dec_err_cnt_o >= 31 && dec_err_cnt_o <= 33), 1);
`endif
      err_mode = 1'b0;

      // Enable gap mid-stream
      do_reset();
      run_stream(60);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
      run_stream(60);
      cyc(1'b0, 1'b0);

      // Mid-stream reset after 40 symbols
      do_reset();
      run_stream(40);
      do_reset();
      run_stream(60);
      cyc(1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/viterbi_codec.md
# viterbi_codec

Rate-1/2, constraint-length-3 convolutional encoder (generators 7/5 octal) and matching hard-decision, 4-state Viterbi decoder in one block. The transmit side encodes one information bit per enabled cycle into a 2-bit symbol. The receive side accepts one (possibly corrupted) 2-bit symbol per enabled cycle and emits decoded bits after a fixed traceback delay. It sits between the user bit stream and the channel/error-injection path in the link test harness.

## Interface
- TB_DEPTH, default 16: survivor (register-exchange) length in symbols; must be ≥ 5.
- PM_W, default 6: path-metric width in bits.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- enc_enable_i  in  1  encoder accepts enc_d_i this cycle.
- enc_d_i  in  1  information bit.
- enc_valid_o  out  1  enc_d_o holds a new symbol.
- enc_d_o  out  2  encoded symbol {g0, g1}.
- dec_enable_i  in  1  decoder accepts dec_d_i this cycle.
- dec_d_i  in  2  received symbol {g0, g1}.
- dec_valid_o  out  1  dec_d_o holds a decoded bit.
- dec_d_o  out  1  decoded information bit.

## Operation
- Encoder state {s1,s0} (s1 is the previous bit). On an enabled cycle with input d:
  - enc_d_o <= {d^s1^s0, d^s0}
  - s1 <= d, s0 <= s1
- When enc_enable_i is low, encoder state and enc_d_o hold.
- Decoder state index is {s1,s0}. Next state n={d,a} has predecessors p0={a,0} and p1={a,1}.
- Expected symbol for predecessor {a,b} with input d: {d^a^b, d^b}.
- Branch metric: Hamming distance (0..2) between dec_d_i and the expected symbol.
- ACS per next state:
  - Candidate cost = pm[p] + bm, saturating at 2^PM_W−1.
  - Choose the smaller cost; on a tie choose p0.
  - surv[n] <= {surv[p_win][TB_DEPTH−2:0], d}, newest bit in the LSB.
- Normalization: after ACS, subtract the minimum of the four new metrics from all four, so the smallest is always 0.
- Output:
  - Best state = minimum new metric; ties go to the lowest index.
  - dec_d_o <= surv_new[best][TB_DEPTH−1].
- Decoder reset values: pm[0]=0; pm[1..3]=16 (saturated to the PM_W maximum if smaller); all survivors 0.
- When dec_enable_i is low, all decoder state holds.
- Encoder and decoder are independent datapaths sharing only clk/rst.

## Timing
- Reset values: enc_d_o=00, enc_valid_o=0, dec_d_o=0, dec_valid_o=0; internal counters cleared.
- Encoder latency is one cycle: enc_valid_o is enc_enable_i delayed one cycle.
- Decoder: dec_d_o updates on the cycle after each enabled symbol.
  - For enabled symbol index j (0-based since reset), dec_d_o is the estimate of the info bit that produced symbol j−(TB_DEPTH−1).
- dec_valid_o pulses one cycle after each enabled symbol with j ≥ TB_DEPTH−1. A saturating warm-up counter gates it.
- Reset asserted mid-stream clears everything on that edge. Enables sampled in the same cycle are ignored.
- No backpressure exists; both sides accept one symbol per enabled cycle, back-to-back.

## Configuration
- VITERBI_ERR_CNT_EN defined:
  - Adds output dec_err_cnt_o [15:0], reset 0.
  - Each enabled decoder cycle, it adds the normalization amount (the pre-normalization minimum metric), saturating at 0xFFFF.
  - It therefore tracks the Hamming weight of channel errors on the best path.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

## Test plan
- Encoder vector: reset, then enable with bits 1,0,1,1,0,0 → enc_d_o = 11,10,00,01,01,11, each one cycle after its input, with enc_valid_o high.
- Clean loopback: 256 random bits, encoder output registered into the decoder with enables aligned → dec_d_o equals input delayed TB_DEPTH−1 symbols, zero mismatches once dec_valid_o is high.
- Error correction: same as loopback, but invert bit[1] of every 8th symbol (indices 7,15,…,255) → zero decoded-bit mismatches.
- Enable gaps: deassert both enables for 5 cycles mid-stream → outputs and metrics hold, decoding resumes error-free, and dec_valid_o stays low during the gap.
- Mid-stream reset: pulse rst for 1 cycle after 40 symbols → all outputs 0, dec_valid_o stays low for the next TB_DEPTH−1 symbols, then decoding is correct.
- VITERBI_ERR_CNT_EN: run the error-correction scenario → dec_err_cnt_o = 32 ±1 after the final symbol; clean loopback → 0.
